// File: rtl/regfile_pkg.sv
// Shared defaults and data/address types for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF   = 32;
  localparam int NUM_RD_DEF     = 2;
  localparam int DBG_REG_DEF    = 10;
  localparam int AW_DEF         = $clog2(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]         reg_addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/busy_table.sv
// One busy bit per register: set by an issued producer, cleared by its write-back.
// A set and a clear that hit the same register on one edge leave it busy.
module busy_table #(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr0_en,
  input  logic [AW-1:0]       clr0_addr,
  input  logic                clr1_en,
  input  logic [AW-1:0]       clr1_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_d, busy_q;

  // NOTE: always_comb starts from a full default so no path leaves busy_d unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr0_en && clr0_addr == AW'(i)) busy_d[i] = 1'b0;
      if (clr1_en && clr1_addr == AW'(i)) busy_d[i] = 1'b0;
      if (set_en  && set_addr  == AW'(i)) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two write ports (port 1 wins), write-to-read bypass,
// per-register busy tracking and a debug mirror of one stored register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int NUM_RD     = NUM_RD_DEF,
  parameter int DBG_REG    = DBG_REG_DEF,
  localparam int AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RD-1:0][AW-1:0]          rd_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]                  rd_busy,
  input  logic                               we0,
  input  logic [AW-1:0]                      wa0,
  input  logic [DATA_WIDTH-1:0]              wd0,
  input  logic                               we1,
  input  logic [AW-1:0]                      wa1,
  input  logic [DATA_WIDTH-1:0]              wd1,
  input  logic                               issue_en,
  input  logic [AW-1:0]                      issue_addr,
  output logic [DATA_WIDTH-1:0]              dbg_data
);

  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_vec;
  logic                  we0_v, we1_v, issue_v;

  // x0 and addresses past the last register are inert for reads, writes and issues.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  assign we0_v   = we0 && addr_ok(wa0);
  assign we1_v   = we1 && addr_ok(wa1);
  assign issue_v = issue_en && addr_ok(issue_addr);

  busy_table #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue_v),
    .set_addr  (issue_addr),
    .clr0_en   (we0_v),
    .clr0_addr (wa0),
    .clr1_en   (we1_v),
    .clr1_addr (wa1),
    .busy      (busy_vec)
  );

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we0_v && wa0 == AW'(i)) regs_d[i] = wd0;
      if (we1_v && wa1 == AW'(i)) regs_d[i] = wd1;
    end
    regs_d[0] = '0;
  end

  // NOTE: the array is reset on purpose: every register must read 0 after rst, not just x0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // A bypassed read returns the incoming write and reports not busy; issues are never bypassed.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (!rst && addr_ok(rd_addr[p])) begin
        if (we1_v && wa1 == rd_addr[p]) begin
          rd_data[p] = wd1;
        end else if (we0_v && wa0 == rd_addr[p]) begin
          rd_data[p] = wd0;
        end else begin
          rd_data[p] = regs_q[rd_addr[p]];
          rd_busy[p] = busy_vec[rd_addr[p]];
        end
      end
    end
  end

  generate
    if (DBG_REG > 0 && DBG_REG < NUM_REGS) begin : g_dbg
      assign dbg_data = rst ? '0 : regs_q[DBG_REG];
    end else begin : g_no_dbg
      assign dbg_data = '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: read expectations are queued when stimulus is driven and
// popped/compared once the combinational read path has settled.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0][AW_DEF-1:0] rd_addr;
  logic [1:0][31:0]      rd_data;
  logic [1:0]            rd_busy;
  logic                  we0, we1, issue_en;
  reg_addr_t             wa0, wa1, issue_addr;
  reg_data_t             wd0, wd1;
  reg_data_t             dbg_data;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string     tag;
    int        port;
    reg_data_t data;
    logic      busy;
  } exp_t;

  exp_t sb[$];

  regfile_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .we0        (we0),
    .wa0        (wa0),
    .wd0        (wd0),
    .we1        (we1),
    .wa1        (wa1),
    .wd1        (wd1),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int port, input reg_addr_t a,
                           input reg_data_t d, input logic b);
    exp_t e;
    rd_addr[port] = a;
    e.tag  = tag;
    e.port = port;
    e.data = d;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".data"}, rd_data[e.port], e.data);
      check({e.tag, ".busy"}, {31'b0, rd_busy[e.port]}, {31'b0, e.busy});
    end
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  // Advance one rising edge; inputs are then driven on the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    @(negedge clk);
    @(negedge clk);
    expect_rd("rst_init_x5", 0, 5'd5, 32'h0, 1'b0);
    drain();
    check("rst_init_dbg", dbg_data, 32'h0);

    // Write x5, mark it busy, then reset asynchronously mid-cycle.
    rst = 1'b0;
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234;
    cycle();
    idle();
    issue_en = 1'b1; issue_addr = 5'd5;
    expect_rd("x5_written", 0, 5'd5, 32'h1234, 1'b0);
    drain();
    cycle();
    idle();
    expect_rd("x5_busy", 0, 5'd5, 32'h1234, 1'b1);
    drain();
    rst = 1'b1;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h99;
    issue_en = 1'b1; issue_addr = 5'd6;
    expect_rd("rst_async_x5", 0, 5'd5, 32'h0, 1'b0);
    drain();
    check("rst_async_dbg", dbg_data, 32'h0);
    cycle();
    rst = 1'b0;
    idle();
    expect_rd("post_rst_x5", 0, 5'd5, 32'h0, 1'b0);
    expect_rd("post_rst_x6", 1, 5'd6, 32'h0, 1'b0);
    drain();

    // x0 ignores writes and issues, including the bypass.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_addr = 5'd0;
    expect_rd("x0_same", 0, 5'd0, 32'h0, 1'b0);
    drain();
    cycle();
    idle();
    expect_rd("x0_next", 0, 5'd0, 32'h0, 1'b0);
    drain();

    // Dual write to x7: port 1 wins in the bypass and in storage.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hBBBB;
    expect_rd("x7_byp_p0", 0, 5'd7, 32'hBBBB, 1'b0);
    expect_rd("x7_byp_p1", 1, 5'd7, 32'hBBBB, 1'b0);
    drain();
    cycle();
    idle();
    expect_rd("x7_stored", 0, 5'd7, 32'hBBBB, 1'b0);
    drain();

    // Scoreboard: issue x3 at n, write-back at n+3.
    issue_en = 1'b1; issue_addr = 5'd3;
    expect_rd("x3_n", 0, 5'd3, 32'h0, 1'b0);
    drain();
    cycle();
    idle();
    expect_rd("x3_n1", 0, 5'd3, 32'h0, 1'b1);
    drain();
    cycle();
    expect_rd("x3_n2", 1, 5'd3, 32'h0, 1'b1);
    drain();
    cycle();
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h55;
    expect_rd("x3_n3_byp", 0, 5'd3, 32'h55, 1'b0);
    drain();
    cycle();
    idle();
    expect_rd("x3_n4", 0, 5'd3, 32'h55, 1'b0);
    drain();

    // Set/clear collision on x9: the new issue keeps it busy.
    issue_en = 1'b1; issue_addr = 5'd9;
    cycle();
    idle();
    issue_en = 1'b1; issue_addr = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h77;
    expect_rd("x9_byp", 0, 5'd9, 32'h77, 1'b0);
    drain();
    cycle();
    idle();
    expect_rd("x9_collide", 0, 5'd9, 32'h77, 1'b1);
    drain();

    // Debug mirror shows stored x10, never the bypass.
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hDEAD;
    #2 check("dbg_write_cycle", dbg_data, 32'h0);
    cycle();
    idle();
    #2 check("dbg_after_edge", dbg_data, 32'hDEAD);

    // Reset held across an edge discards that cycle's write and issue.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h42;
    issue_en = 1'b1; issue_addr = 5'd13;
    #1 rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle();
    expect_rd("x12_discard", 0, 5'd12, 32'h0, 1'b0);
    expect_rd("x13_discard", 1, 5'd13, 32'h0, 1'b0);
    drain();
    check("dbg_cleared", dbg_data, 32'h0);

    // Operation resumes on the first edge after reset release.
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'hCAFE;
    cycle();
    idle();
    expect_rd("x12_resume", 0, 5'd12, 32'hCAFE, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
